// File: rtl/ksa_pipe_if.sv
// Operand/result handshake bundle for ksa_pipe: producer-side beat (valid/ready,
// operands, mode, tag) and consumer-side result (valid/ready, sum, flags, tag).
interface ksa_pipe_if #(
  parameter int N     = 4,
  parameter int TAG_W = 1
);
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     a;
  logic [N-1:0]     b;
  logic             cin;
  logic             sub;
  logic [TAG_W-1:0] tag_in;
  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     s;
  logic             cout;
  logic             ovf;
  logic [TAG_W-1:0] tag_out;

  modport master (
    output in_valid, a, b, cin, sub, tag_in, out_ready,
    input  in_ready, out_valid, s, cout, ovf, tag_out
  );

  modport slave (
    input  in_valid, a, b, cin, sub, tag_in, out_ready,
    output in_ready, out_valid, s, cout, ovf, tag_out
  );
endinterface

// File: rtl/ksa_pipe.sv
// Pipelined Kogge-Stone adder/subtractor with valid/ready flow control.
// Stage 0 forms (g, p); prefix levels are grouped LPS per registered stage.
module ksa_pipe #(
  parameter int N     = 4,
  parameter int LPS   = 1,
  parameter int TAG_W = 1
) (
  input logic       clk,
  input logic       reset_n,
  ksa_pipe_if.slave bus
);
  localparam int K = $clog2(N);
  localparam int P = (K + LPS - 1) / LPS;

  typedef struct packed {
    logic [N-1:0] g;
    logic [N-1:0] p;
  } gp_t;

  // One Kogge-Stone level. Spans that run past bit 0 get p=0, which is exactly the
  // virtual bit -1 (g=c0, p=0); their g was already completed via the bit-0 fold.
  function automatic gp_t prefix_level(input gp_t x, input int lvl);
    gp_t y;
    int  d;
    d   = 32'sd1 << lvl;
    y.g = x.g | (x.p & (x.g << d));
    y.p = x.p & (x.p << d);
    return y;
  endfunction

  logic             en;
  logic [N-1:0]     b_eff;
  logic             c0_in;

  logic [N-1:0]     g_d   [0:P];
  logic [N-1:0]     p_d   [0:P];
  logic [N-1:0]     pr_d  [0:P];
  logic             c0_d  [0:P];
  logic [TAG_W-1:0] tag_d [0:P];
  logic             v_d   [0:P];

  logic [N-1:0]     g_q   [0:P];
  logic [N-1:0]     p_q   [0:P];
  logic [N-1:0]     pr_q  [0:P];
  logic             c0_q  [0:P];
  logic [TAG_W-1:0] tag_q [0:P];
  logic             v_q   [0:P];

  logic [N-1:0]     cy_s;
  logic [N-1:0]     sum_s;
  logic             cout_s;
  logic             ovf_s;

  logic             out_v_q;
  logic [N-1:0]     s_q;
  logic             cout_q;
  logic             ovf_q;
  logic [TAG_W-1:0] tag_out_q;

  // Stage 0 operand conditioning plus the prefix levels feeding every later stage.
  always_comb begin
    gp_t gp;
    if (bus.sub) begin
      b_eff = ~bus.b;
      c0_in = 1'b1;
    end else begin
      b_eff = bus.b;
      c0_in = bus.cin;
    end

    g_d[0]    = bus.a & b_eff;
    p_d[0]    = bus.a ^ b_eff;
    g_d[0][0] = g_d[0][0] | (p_d[0][0] & c0_in);
    pr_d[0]   = p_d[0];
    c0_d[0]   = c0_in;
    tag_d[0]  = bus.tag_in;
    v_d[0]    = bus.in_valid;

    for (int j = 1; j <= P; j++) begin
      gp.g = g_q[j-1];
      gp.p = p_q[j-1];
      // The last stage is short when K is not a multiple of LPS.
      for (int l = (j - 1) * LPS; l < ((j * LPS < K) ? j * LPS : K); l++) begin
        gp = prefix_level(gp, l);
      end
      g_d[j]   = gp.g;
      p_d[j]   = gp.p;
      pr_d[j]  = pr_q[j-1];
      c0_d[j]  = c0_q[j-1];
      tag_d[j] = tag_q[j-1];
      v_d[j]   = v_q[j-1];
    end
  end

  // Carries from the completed prefix: bit 0 sees c0, bit i sees G[i-1:-1].
  always_comb begin
    cy_s   = {g_q[P][N-2:0], c0_q[P]};
    sum_s  = pr_q[P] ^ cy_s;
    cout_s = g_q[P][N-1];
    ovf_s  = cy_s[N-1] ^ g_q[P][N-1];
  end

  // Pipeline and output registers; a stall freezes every stage including valids.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int j = 0; j <= P; j++) begin
        g_q[j]   <= {N{1'b0}};
        p_q[j]   <= {N{1'b0}};
        pr_q[j]  <= {N{1'b0}};
        c0_q[j]  <= 1'b0;
        tag_q[j] <= {TAG_W{1'b0}};
        v_q[j]   <= 1'b0;
      end
      out_v_q   <= 1'b0;
      s_q       <= {N{1'b0}};
      cout_q    <= 1'b0;
      ovf_q     <= 1'b0;
      tag_out_q <= {TAG_W{1'b0}};
    end else if (en) begin
      for (int j = 0; j <= P; j++) begin
        g_q[j]   <= g_d[j];
        p_q[j]   <= p_d[j];
        pr_q[j]  <= pr_d[j];
        c0_q[j]  <= c0_d[j];
        tag_q[j] <= tag_d[j];
        v_q[j]   <= v_d[j];
      end
      out_v_q   <= v_q[P];
      s_q       <= sum_s;
      cout_q    <= cout_s;
      ovf_q     <= ovf_s;
      tag_out_q <= tag_q[P];
    end
  end

  // in_ready follows out_ready combinationally; it never looks at in_valid.
  assign en            = ~out_v_q | bus.out_ready;
  assign bus.in_ready  = en;
  assign bus.out_valid = out_v_q;
  assign bus.s         = s_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
  assign bus.tag_out   = tag_out_q;
endmodule
